// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, a centre-sampling FSM
// and a small first-word-fall-through receive FIFO with sticky error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        rx_s1;
  logic        rx_s;
  logic [15:0] div;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   rem;

  logic stop_hit;
  logic push;
  logic ferr_set;
  logic pop;
  logic full;
  logic wr_ok;
  logic drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx_bit;
      rx_s  <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            div     <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (div == HALF) begin
            div   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            div <= div + 16'd1;
          end
        end
        DATA: begin
          if (div == FULL) begin
            div     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            div <= div + 16'd1;
          end
        end
        STOP: begin
          if (div == FULL) begin
            div   <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else begin
            div <= div + 16'd1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-sample decode feeds the FIFO directly so the byte lands this edge
  assign stop_hit = (state == STOP) && (div == FULL);
  assign push     = stop_hit && rx_s;
  assign ferr_set = stop_hit && !rx_s;

  assign full       = (count == DEPTH);
  assign data_valid = (count != '0);
  assign fifo_full  = full;
  assign pop        = rd_en && data_valid;
  assign wr_ok      = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rd_nxt     = rd_ptr + AW'(pop);
  assign rem        = count - (AW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= shreg;
  end

  // data_out is registered so it keeps the last head once the FIFO drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_nxt;
      count <= count + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
      if (rem != '0) begin
        data_out <= mem[rd_nxt];
      end else if (wr_ok) begin
        data_out <= shreg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames against a queue-level receive model
// plus literal checks at the end of each scenario.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // sync (2) + idle detect (1) + half bit + 9 full bits to the stop sample
  localparam int LAT   = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic       fifo_full;
  logic       overrun;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_bit    (rx_bit),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .data_valid(data_valid),
    .fifo_full (fifo_full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] q[$];
  bit         m_ovr  = 1'b0;
  bit         m_fe   = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         m_pop;
  bit         m_push;
  bit         m_setf;
  bit         m_seto;
  logic [7:0] m_d;
  ev_t        m_ev;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Receive model: a frame lands LAT edges after its start bit is driven
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        evq.delete();
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
        m_dout = 8'h00;
      end else begin
        m_pop  = rd_en && (q.size() != 0);
        m_push = 1'b0;
        m_setf = 1'b0;
        m_seto = 1'b0;
        m_d    = 8'h00;
        if (evq.size() != 0 && evq[0].at == cyc + 1) begin
          m_ev = evq.pop_front();
          m_d  = m_ev.d;
          if (m_ev.ok) m_push = 1'b1;
          else m_setf = 1'b1;
        end
        if (m_push && q.size() == DEPTH && !m_pop) begin
          m_push = 1'b0;
          m_seto = 1'b1;
        end
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(m_d);
        if (clr_err) begin
          m_ovr = 1'b0;
          m_fe  = 1'b0;
        end
        if (m_seto) m_ovr = 1'b1;
        if (m_setf) m_fe = 1'b1;
        if (q.size() != 0) m_dout = q[0];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_data_valid", data_valid, q.size() != 0);
      chk("cyc_fifo_full", fifo_full, q.size() == DEPTH);
      chk("cyc_data_out", data_out, m_dout);
      chk("cyc_overrun", overrun, m_ovr);
      chk("cyc_frame_err", frame_err, m_fe);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr1();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_val = 1'b1,
                      input int stop_len = CPB, input int pop_at = -1,
                      input int rst_at = -1);
    ev_t e;
    e.at = cyc + LAT;
    e.d  = b;
    e.ok = stop_val;
    evq.push_back(e);
    for (int c = 0; c < 9 * CPB + stop_len; c++) begin
      int idx;
      idx = c / CPB;
      if (c == rst_at) begin
        reset  = 1'b0;
        rx_bit = 1'b1;
        rd_en  = 1'b0;
        @(negedge clk);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        idle(3);
        reset = 1'b1;
        idle(2);
        return;
      end
      if (idx == 0) rx_bit = 1'b0;
      else if (idx <= 8) rx_bit = b[idx-1];
      else rx_bit = stop_val;
      rd_en = (c == pop_at);
      @(negedge clk);
    end
    rx_bit = 1'b1;
    rd_en  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    rx_bit  = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    idle(3);
    chk_en = 1'b1;
    chk("init_valid", data_valid, 0);
    chk("init_data", data_out, 8'h00);
    chk("init_full", fifo_full, 0);
    chk("init_flags", {overrun, frame_err}, 2'b00);
    reset = 1'b1;
    idle(5);

    send(8'h41);
    chk("b41_valid", data_valid, 1);
    chk("b41_data", data_out, 8'h41);
    pop1();
    chk("b41_popped", data_valid, 0);

    rx_bit = 1'b0;
    idle(4);
    rx_bit = 1'b1;
    idle(30);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_flags", {overrun, frame_err}, 2'b00);

    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ovr_full", fifo_full, 1);
    chk("ovr_flag", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_order", data_out, i);
      pop1();
    end
    chk("ovr_drained", data_valid, 0);
    clr1();
    chk("ovr_clr", overrun, 0);

    send(8'h55, 1'b0, 40);
    idle(5);
    chk("ferr_set", frame_err, 1);
    chk("ferr_nopush", data_valid, 0);
    clr1();
    chk("ferr_clr", frame_err, 0);
    idle(5);
    send(8'hA5);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid", data_valid, 1);
    pop1();

    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    chk("pp_full_pre", fifo_full, 1);
    send(8'h77, 1'b1, CPB, LAT - 1);
    chk("pp_ovr", overrun, 0);
    chk("pp_full", fifo_full, 1);
    chk("pp_head", data_out, 8'h11);
    pop1();
    pop1();
    chk("pp_third", data_out, 8'h13);
    pop1();
    chk("pp_last", data_out, 8'h77);
    pop1();
    chk("pp_empty", data_valid, 0);

    send(8'h99);
    chk("pre_rst_valid", data_valid, 1);
    send(8'h3C, 1'b1, CPB, -1, 4 * CPB + 6);
    chk("post_rst_valid", data_valid, 0);
    idle(5);
    send(8'h3C);
    chk("b3c_data", data_out, 8'h3C);
    chk("b3c_valid", data_valid, 1);
    pop1();
    chk("b3c_popped", data_valid, 0);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1250, meaning clk cycles per serial bit (12 MHz / 9600 baud); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; power of two, 2..16.
REQ-003 The block SHALL have port clk, input, 1, single reference clock (12 MHz); all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 => reset), deassertion synchronous to clk.
REQ-005 The block SHALL have port rx_bit, input, 1, asynchronous UART RX pin, idle high, 8N1 LSB first.
REQ-006 The block SHALL have port rd_en, input, 1, pop request for the FIFO head.
REQ-007 The block SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-008 The block SHALL have port data_out, output, 8, FIFO head byte.
REQ-009 The block SHALL have port data_valid, output, 1, FIFO not empty.
REQ-010 The block SHALL have port fifo_full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-011 The block SHALL have port overrun, output, 1, sticky: byte dropped because FIFO full.
REQ-012 The block SHALL have port frame_err, output, 1, sticky: stop bit sampled low.

Function
REQ-013 rx_bit SHALL pass a 2-flop synchronizer (reset value 1) before any use; the FSM sees only the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK; reset state IDLE.
REQ-015 IDLE: synchronized rx = 0 -> START, bit counter cleared, clock-divider counter cleared.
REQ-016 START: at divider count CLKS_PER_BIT/2 - 1 sample rx; 0 -> DATA with divider cleared; 1 -> IDLE (glitch rejected, nothing recorded).
REQ-017 DATA: every CLKS_PER_BIT cycles sample rx into shift register, LSB first; after the 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> push byte, go IDLE; 0 -> set frame_err, discard byte, go BREAK.
REQ-019 BREAK: remain until synchronized rx = 1, then -> IDLE.
REQ-020 Push SHALL write the FIFO on the stop-sample cycle; data_valid rises the next cycle (FIFO latency 1 clk).
REQ-021 FIFO SHALL be first-word fall-through: data_out equals the oldest byte whenever data_valid = 1; data_out holds last value when empty.
REQ-022 rd_en with data_valid = 1 SHALL pop one entry; rd_en with data_valid = 0 SHALL be ignored.
REQ-023 Push while full and no pop SHALL drop the new byte, set overrun, leave FIFO contents unchanged.
REQ-024 Push and pop in the same cycle SHALL both occur, including when full (no overrun) and when empty-plus-push is not possible (pop ignored).
REQ-025 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy counter one bit wider.
REQ-026 clr_err SHALL clear overrun and frame_err next cycle; a same-cycle set event SHALL win over clr_err.
REQ-027 Divider counter SHALL be 16 bits wide; no dependence on baud beyond CLKS_PER_BIT.

Reset
REQ-028 reset = 0 SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, FIFO empty, data_out 0x00, data_valid 0, fifo_full 0, overrun 0, frame_err 0.
REQ-029 reset asserted mid-frame SHALL abort the frame with no push; after release the next complete frame SHALL be received normally.

Verification (bench uses CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-030 Send 0x41 -> data_valid = 1 one clk after stop sample, data_out = 0x41; pulse rd_en -> data_valid = 0.
REQ-031 Send 0x01..0x05 without pops -> fifo_full = 1, overrun = 1, pops return 0x01,0x02,0x03,0x04 only.
REQ-032 Drive rx_bit low 4 clks then high -> no push, FSM back in IDLE, no flags set.
REQ-033 Send 0x55 with stop bit 0 held low 40 clks -> frame_err = 1, FIFO empty; clr_err -> frame_err = 0; next 0xA5 frame received.
REQ-034 FIFO full, rd_en asserted on stop-sample cycle of 0x77 -> overrun = 0, occupancy stays 4, last entry 0x77.
REQ-035 reset low during DATA bit 3 -> all outputs at reset values; after release send 0x3C -> data_out = 0x3C.
